// File: rtl/fft_buf_pkg.sv
// fft_buf_pkg -- shared definitions for the FFT bin ping-pong buffer.
//
// Contents:
//   DEF_N_BINS / DEF_ADDR_W / DEF_DATA_W : default frame geometry
//   DROP_W / DROP_MAX                    : dropped-frame counter width and saturation value
//   wr_state_e                           : write FSM state encoding
package fft_buf_pkg;

  localparam int DEF_N_BINS = 512;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 18;

  localparam int              DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // IDLE: waiting for the first bin of a frame.
  // FILL: storing a frame into bank wr_bank.
  // DROP: discarding a frame (no free bank, or stream out of sync).
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/fft_bin_buffer_bin_ram.sv
// bin_ram -- simple dual-port RAM holding both frame banks.
//
// Ports:
//   clk    : clock
//   reset  : synchronous active-high; clears only the read output register
//   we     : write enable
//   waddr  : write address {bank, bin}
//   wdata  : write data {real, imag}
//   re     : read enable; rdata updates one cycle later, otherwise holds
//   raddr  : read address {bank, bin}
//   rdata  : registered read data
//
// Memory contents are never cleared.
module bin_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_bin_buffer.sv
// fft_bin_buffer -- ping-pong bin store between the FFT core and main_fsm.
//
// The FFT output stream is written into one bank while main_fsm reads the
// other one through random-access reads.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   xk_valid        : FFT output bin valid
//   xk_index        : bin index of the current output
//   xk_re, xk_im    : bin value (signed)
//   fft_done        : a complete frame is readable (level, registered)
//   frame_release   : one-cycle pulse, consumer is finished with the frame
//   fft_address     : read bin address
//   read_enable     : read request
//   fft_read_valid  : read data valid
//   data_out_real   : bin real part
//   data_out_imag   : bin imaginary part
//   data_out_mag    : |re|,|im| magnitude estimate (FFT_BUF_MAG_EN only)
//   busy            : write FSM is not idle
//   drop_count      : frames dropped for lack of a free bank, saturating
//   wr_state        : write FSM state (debug)
//
// Build option FFT_BUF_MAG_EN adds data_out_mag and one more output
// register stage (read latency 2 instead of 1; all read outputs stay aligned).
module fft_bin_buffer
  import fft_buf_pkg::*;
#(
  parameter int N_BINS = DEF_N_BINS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     xk_valid,
  input  logic [ADDR_W-1:0]        xk_index,
  input  logic signed [DATA_W-1:0] xk_re,
  input  logic signed [DATA_W-1:0] xk_im,
  output logic                     fft_done,
  input  logic                     frame_release,
  input  logic [ADDR_W-1:0]        fft_address,
  input  logic                     read_enable,
  output logic                     fft_read_valid,
  output logic signed [DATA_W-1:0] data_out_real,
  output logic signed [DATA_W-1:0] data_out_imag,
`ifdef FFT_BUF_MAG_EN
  output logic [DATA_W:0]          data_out_mag,
`endif
  output logic                     busy,
  output logic [DROP_W-1:0]        drop_count,
  output wr_state_e                wr_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BINS - 1);

  // Read handshake: a request is accepted when read_enable is high in a
  // cycle where fft_done is high; exactly one accepted request produces one
  // fft_read_valid pulse a fixed latency later. Requests while fft_done is
  // low are dropped and the data outputs keep their last value. There is no
  // back-pressure on the read path.

  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] full;
  logic [1:0] full_next;
  logic       rd_bank_next;

  logic       first_beat;
  logic       last_beat;
  logic       bank_free;
  logic       fill_done;
  logic       release_ok;
  logic       rd_accept;
  logic       ram_we;

  logic [2*DATA_W-1:0] ram_rdata;
  logic                rd_valid_q;

  assign first_beat = xk_valid && (xk_index == '0);
  assign last_beat  = xk_valid && (xk_index == LAST_IDX);
  assign bank_free  = !full[wr_bank];
  assign fill_done  = (wr_state == WR_FILL) && last_beat;
  assign release_ok = frame_release && fft_done;
  assign rd_accept  = read_enable && fft_done;

  // The first bin is written in the same cycle IDLE decides to accept it.
  assign ram_we = ((wr_state == WR_IDLE) && first_beat && bank_free) ||
                  ((wr_state == WR_FILL) && xk_valid);

  // ---------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state   <= WR_IDLE;
      wr_bank    <= 1'b0;
      busy       <= 1'b0;
      drop_count <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (xk_valid) begin
            busy <= 1'b1;
            if (first_beat && bank_free) begin
              wr_state <= WR_FILL;
            end else begin
              // Only a real frame start with no free bank counts as a drop;
              // a stream picked up mid-frame is just resynchronised.
              wr_state <= WR_DROP;
              if (first_beat && (drop_count != DROP_MAX)) begin
                drop_count <= drop_count + DROP_W'(1);
              end
            end
          end
        end
        WR_FILL: begin
          if (last_beat) begin
            wr_state <= WR_IDLE;
            busy     <= 1'b0;
            wr_bank  <= ~wr_bank;
          end
        end
        WR_DROP: begin
          if (last_beat) begin
            wr_state <= WR_IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          wr_state <= WR_IDLE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Bank ownership and fft_done
  // ---------------------------------------------------------------------
  // A completion and a release in the same cycle always touch different
  // banks: a fill only starts into a free bank, and a release needs a full
  // read bank, so wr_bank != rd_bank while both can happen.
  always_comb begin
    full_next = full;
    if (fill_done) begin
      full_next[wr_bank] = 1'b1;
    end
    if (release_ok) begin
      full_next[rd_bank] = 1'b0;
    end
  end

  assign rd_bank_next = rd_bank ^ release_ok;

  // fft_done follows the post-update full flag of the read bank so it rises
  // in the cycle right after the completing write. A release forces one low
  // cycle so the consumer always sees a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      full     <= 2'b00;
      rd_bank  <= 1'b0;
      fft_done <= 1'b0;
    end else begin
      full     <= full_next;
      rd_bank  <= rd_bank_next;
      fft_done <= full_next[rd_bank_next] && !release_ok;
    end
  end

  // ---------------------------------------------------------------------
  // Bin RAM
  // ---------------------------------------------------------------------
  bin_ram #(
    .ADDR_W (ADDR_W + 1),
    .DATA_W (2 * DATA_W)
  ) u_bin_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr ({wr_bank, xk_index}),
    .wdata ({xk_re, xk_im}),
    .re    (rd_accept),
    .raddr ({rd_bank, fft_address}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
    end
  end

`ifdef FFT_BUF_MAG_EN
  // ---------------------------------------------------------------------
  // Magnitude estimate stage: max(|re|,|im|) + min(|re|,|im|)/2
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] rd_re;
  logic [DATA_W-1:0] rd_im;
  logic [DATA_W-1:0] abs_re;
  logic [DATA_W-1:0] abs_im;
  logic [DATA_W-1:0] mag_max;
  logic [DATA_W-1:0] mag_min;
  logic [DATA_W:0]   mag_calc;

  logic              valid_q2;
  logic [DATA_W-1:0] real_q2;
  logic [DATA_W-1:0] imag_q2;
  logic [DATA_W:0]   mag_q2;

  assign rd_re = ram_rdata[2*DATA_W-1:DATA_W];
  assign rd_im = ram_rdata[DATA_W-1:0];

  // Unsigned absolute value: the most negative input maps to 2^(DATA_W-1),
  // which still fits in DATA_W unsigned bits.
  always_comb begin
    abs_re   = rd_re[DATA_W-1] ? (~rd_re + DATA_W'(1)) : rd_re;
    abs_im   = rd_im[DATA_W-1] ? (~rd_im + DATA_W'(1)) : rd_im;
    mag_max  = (abs_re >= abs_im) ? abs_re : abs_im;
    mag_min  = (abs_re >= abs_im) ? abs_im : abs_re;
    mag_calc = {1'b0, mag_max} + {2'b00, mag_min[DATA_W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q2 <= 1'b0;
      real_q2  <= '0;
      imag_q2  <= '0;
      mag_q2   <= '0;
    end else begin
      valid_q2 <= rd_valid_q;
      if (rd_valid_q) begin
        real_q2 <= rd_re;
        imag_q2 <= rd_im;
        mag_q2  <= mag_calc;
      end
    end
  end

  assign fft_read_valid = valid_q2;
  assign data_out_real  = real_q2;
  assign data_out_imag  = imag_q2;
  assign data_out_mag   = mag_q2;
`else
  assign fft_read_valid = rd_valid_q;
  assign data_out_real  = ram_rdata[2*DATA_W-1:DATA_W];
  assign data_out_imag  = ram_rdata[DATA_W-1:0];
`endif

endmodule
